// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: takes operands A and B MSB-first, one bit pair per
// accepted beat, and reports greater/equal/less on registered flags after WIDTH beats.
module serial_magnitude_comparator #(
  parameter int WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       bit_valid,
  input  logic                       a_bit,
  input  logic                       b_bit,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       A_greater_B,
  output logic                       A_equal_B,
  output logic                       A_less_B
);

  // state  | meaning
  // IDLE   | waiting for start; flags and bit_count hold the last result
  // SHIFT  | accepting bit pairs MSB-first, bit_valid may stall
  // REPORT | one cycle: done=1, flags carry the final result

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(WIDTH-1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          decided_q, decided_d;
  logic          gt_q, gt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          gtf_q, gtf_d;
  logic          eqf_q, eqf_d;
  logic          ltf_q, ltf_d;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    decided_d = decided_q;
    gt_d      = gt_q;
    gtf_d     = gtf_q;
    eqf_d     = eqf_q;
    ltf_d     = ltf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          count_d   = '0;
          decided_d = 1'b0;
          gt_d      = 1'b0;
          gtf_d     = 1'b0;
          eqf_d     = 1'b0;
          ltf_d     = 1'b0;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          count_d = count_q + CW'(1);
          // Only the most significant differing bit decides the outcome.
          if (!decided_q && (a_bit != b_bit)) begin
            decided_d = 1'b1;
            gt_d      = a_bit;
          end
          if (count_q == LAST_BEAT) begin
            state_d = REPORT;
            eqf_d   = ~decided_d;
            gtf_d   = decided_d & gt_d;
            ltf_d   = decided_d & ~gt_d;
          end
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == REPORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gtf_q     <= 1'b0;
      eqf_q     <= 1'b0;
      ltf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      gtf_q     <= gtf_d;
      eqf_q     <= eqf_d;
      ltf_q     <= ltf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign bit_count   = count_q;
  assign A_greater_B = gtf_q;
  assign A_equal_B   = eqf_q;
  assign A_less_B    = ltf_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for the bit-serial comparator: table vectors, hand-written corner sequences and
// random operands checked against plain integer comparison, on WIDTH=3 and WIDTH=8 instances.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic start3 = 0, bv3 = 0, a3 = 0, b3 = 0;
  logic busy3, done3, gt3, eq3, lt3;
  logic [1:0] cnt3;

  logic start8 = 0, bv8 = 0, a8 = 0, b8 = 0;
  logic busy8, done8, gt8, eq8, lt8;
  logic [3:0] cnt8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .bit_valid(bv3), .a_bit(a3), .b_bit(b3),
    .busy(busy3), .done(done3), .bit_count(cnt3),
    .A_greater_B(gt3), .A_equal_B(eq3), .A_less_B(lt3)
  );

  serial_magnitude_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .bit_valid(bv8), .a_bit(a8), .b_bit(b8),
    .busy(busy8), .done(done8), .bit_count(cnt8),
    .A_greater_B(gt8), .A_equal_B(eq8), .A_less_B(lt8)
  );

  typedef struct {
    int         w;
    logic [7:0] a;
    logic [7:0] b;
    int         stall_idx;
    int         stall_n;
    logic       start_on_last;
    logic [2:0] exp_flags;   // {greater, equal, less}
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int w, input logic s, input logic v, input logic a, input logic b);
    if (w == 8) begin
      start8 = s; bv8 = v; a8 = a; b8 = b;
    end else begin
      start3 = s; bv3 = v; a3 = a; b3 = b;
    end
  endtask

  task automatic sample(input int w, output logic bz, output logic dn,
                        output logic [7:0] cnt, output logic [2:0] fl);
    if (w == 8) begin
      bz = busy8; dn = done8; cnt = {4'b0, cnt8}; fl = {gt8, eq8, lt8};
    end else begin
      bz = busy3; dn = done3; cnt = {6'b0, cnt3}; fl = {gt3, eq3, lt3};
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer comparison of the operands masked to the width.
  function automatic logic [2:0] model(input int w, input logic [7:0] a, input logic [7:0] b);
    int unsigned av, bv;
    av = a & ((1 << w) - 1);
    bv = b & ((1 << w) - 1);
    return {av > bv, av == bv, av < bv};
  endfunction

  // Starts at the current cycle; returns in the IDLE cycle after REPORT.
  task automatic do_compare(input int w, input logic [7:0] a, input logic [7:0] b,
                            input int stall_idx, input int stall_n, input logic sol,
                            input logic [2:0] exp, input string tag);
    logic bz, dn;
    logic [7:0] cnt;
    logic [2:0] fl;
    set_in(w, 1, 0, 0, 0);
    step();
    set_in(w, 0, 0, 0, 0);
    sample(w, bz, dn, cnt, fl);
    chk({tag, " shift busy"}, 32'(bz), 32'd1);
    chk({tag, " shift cnt0"}, 32'(cnt), 32'd0);
    chk({tag, " shift flags"}, 32'(fl), 32'd0);
    for (int i = w - 1; i >= 0; i--) begin
      set_in(w, sol && (i == 0), 1, a[i], b[i]);
      step();
      set_in(w, 0, 0, 0, 0);
      if (i > 0) begin
        sample(w, bz, dn, cnt, fl);
        chk({tag, " beat cnt"}, 32'(cnt), 32'(w - i));
        chk({tag, " beat done"}, 32'(dn), 32'd0);
        chk({tag, " beat flags"}, 32'(fl), 32'd0);
        if (i == stall_idx) begin
          for (int s = 0; s < stall_n; s++) begin
            step();
            sample(w, bz, dn, cnt, fl);
            chk({tag, " stall cnt"}, 32'(cnt), 32'(w - i));
            chk({tag, " stall done"}, 32'(dn), 32'd0);
          end
        end
      end
    end
    sample(w, bz, dn, cnt, fl);
    chk({tag, " report done"}, 32'(dn), 32'd1);
    chk({tag, " report busy"}, 32'(bz), 32'd1);
    chk({tag, " report cnt"}, 32'(cnt), 32'(w));
    chk({tag, " report flags"}, 32'(fl), 32'(exp));
    step();
    sample(w, bz, dn, cnt, fl);
    chk({tag, " idle done"}, 32'(dn), 32'd0);
    chk({tag, " idle busy"}, 32'(bz), 32'd0);
    chk({tag, " idle cnt"}, 32'(cnt), 32'(w));
    chk({tag, " idle flags"}, 32'(fl), 32'(exp));
  endtask

  initial begin
    logic bz, dn;
    logic [7:0] cnt, ra, rb;
    logic [2:0] fl;
    int w, sidx;

    tbl[0] = '{3, 8'b000, 8'b000, -1, 0, 1'b0, 3'b010};
    tbl[1] = '{3, 8'b001, 8'b010, -1, 0, 1'b0, 3'b001};
    tbl[2] = '{3, 8'b011, 8'b010, -1, 0, 1'b0, 3'b100};
    tbl[3] = '{3, 8'b111, 8'b111, -1, 0, 1'b0, 3'b010};
    tbl[4] = '{3, 8'b100, 8'b011, -1, 0, 1'b0, 3'b100};
    tbl[5] = '{3, 8'b100, 8'b011,  2, 2, 1'b0, 3'b100};
    tbl[6] = '{8, 8'hFF,  8'hFE,  -1, 0, 1'b0, 3'b100};
    tbl[7] = '{8, 8'h7F,  8'h80,  -1, 0, 1'b0, 3'b001};
    tbl[8] = '{3, 8'b110, 8'b101, -1, 0, 1'b1, 3'b100};

    #12;
    sample(3, bz, dn, cnt, fl);
    chk("reset3 busy", 32'(bz), 0); chk("reset3 done", 32'(dn), 0);
    chk("reset3 cnt", 32'(cnt), 0); chk("reset3 flags", 32'(fl), 0);
    sample(8, bz, dn, cnt, fl);
    chk("reset8 busy", 32'(bz), 0); chk("reset8 flags", 32'(fl), 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Entries 2 and 3 run back-to-back: start lands in the IDLE cycle right after REPORT.
    for (int k = 0; k < 9; k++)
      do_compare(tbl[k].w, tbl[k].a, tbl[k].b, tbl[k].stall_idx, tbl[k].stall_n,
                 tbl[k].start_on_last, tbl[k].exp_flags, $sformatf("tbl%0d", k));

    // start mid-SHIFT is ignored, bit_valid in IDLE is ignored
    set_in(3, 1, 0, 0, 0); step();
    set_in(3, 0, 1, 1, 0); step();
    set_in(3, 1, 0, 0, 0); step();
    set_in(3, 0, 0, 0, 0);
    sample(3, bz, dn, cnt, fl);
    chk("midstart cnt", 32'(cnt), 1); chk("midstart busy", 32'(bz), 1);
    set_in(3, 0, 1, 0, 1); step();
    set_in(3, 0, 1, 0, 1); step();
    set_in(3, 0, 0, 0, 0);
    sample(3, bz, dn, cnt, fl);
    chk("midstart done", 32'(dn), 1); chk("midstart flags", 32'(fl), 32'b100);
    step();
    set_in(3, 0, 1, 0, 1); step();
    set_in(3, 0, 0, 0, 0); step();
    sample(3, bz, dn, cnt, fl);
    chk("idle bv cnt", 32'(cnt), 3); chk("idle bv busy", 32'(bz), 0);
    chk("idle bv flags", 32'(fl), 32'b100);

    // reset after two beats discards the partial compare
    set_in(3, 1, 0, 0, 0); step();
    set_in(3, 0, 1, 0, 1); step();
    set_in(3, 0, 1, 1, 0); step();
    set_in(3, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    sample(3, bz, dn, cnt, fl);
    chk("midrst busy", 32'(bz), 0); chk("midrst cnt", 32'(cnt), 0);
    chk("midrst flags", 32'(fl), 0); chk("midrst done", 32'(dn), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    do_compare(3, 8'b010, 8'b010, -1, 0, 1'b0, 3'b010, "post_rst");

    // random operands and stalls against the integer model
    for (int r = 0; r < 40; r++) begin
      w  = (r % 2 == 0) ? 3 : 8;
      ra = 8'($urandom_range(0, (1 << w) - 1));
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, (1 << w) - 1));
      sidx = $urandom_range(0, w - 1);
      do_compare(w, ra, rb, (sidx == 0) ? -1 : sidx, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 model(w, ra, rb), $sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
